// File: rtl/frame_copy_pkg.sv
`default_nettype none
// ============================================================================
// Package     : frame_copy_pkg
// Description : Shared types and defaults for the frame copy controller:
//               copy engine state encoding and buffer geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_copy_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    // Copy engine states; ARMED behaves like IDLE for memory muxing
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage : frame_copy_pkg
`default_nettype wire

// File: rtl/frame_copy_pipe.sv
`default_nettype none
// ============================================================================
// Module      : frame_copy_pipe
// Description : READ_LATENCY-deep delay line carrying the read address and
//               a valid flag, so each shadow read lines up with its data on
//               shd_q and becomes the matching pixel write.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_copy_pipe #(
    parameter int ADDR_W       = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    logic [READ_LATENCY-1:0]             valid_q, valid_d;
    logic [READ_LATENCY-1:0][ADDR_W-1:0] addr_q,  addr_d;

    // Stage 0 takes the new read, each later stage takes its predecessor
    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        valid_d[0] = i_valid;
        addr_d[0]  = i_addr;
        for (int s = 1; s < READ_LATENCY; s++) begin
            valid_d[s] = valid_q[s-1];
            addr_d[s]  = addr_q[s-1];
        end
    end

    // Delay line registers; reset flushes any in-flight reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign o_valid = valid_q[READ_LATENCY-1];
    assign o_addr  = addr_q[READ_LATENCY-1];

endmodule : frame_copy_pipe
`default_nettype wire

// File: rtl/frame_copy_controller.sv
`default_nettype none
// ============================================================================
// Module      : frame_copy_controller
// Description : Shadow-to-pixel buffer copy engine. The CPU arms a copy,
//               the engine waits for vblank_start and then streams one byte
//               per cycle from the shadow RAM into pixel RAM port A. The CPU
//               owns both RAMs when the engine is idle or armed and is
//               stalled through cpu_waitrequest while the engine copies.
//               Optional macro FRAME_COPY_IRQ_EN adds copy_done_irq/irq_ack.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_copy_controller
    import frame_copy_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              copy_req,
    input  logic [ADDR_W-1:0] copy_base,
    input  logic [ADDR_W:0]   copy_len,
    input  logic              vblank_start,
    input  logic              vblank,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_chipselect,
    input  logic              cpu_sel_shadow,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] pix_address,
    output logic              pix_wren,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] shd_address,
    output logic              shd_wren,
    output logic [DATA_W-1:0] shd_data,
    input  logic [DATA_W-1:0] shd_q,
    output logic              busy,
    output logic              overrun
`ifdef FRAME_COPY_IRQ_EN
    ,
    output logic              copy_done_irq,
    input  logic              irq_ack
`endif
);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [ADDR_W:0]   len_q,       len_d;
    logic [ADDR_W:0]   cnt_q,       cnt_d;
    logic [1:0]        drain_q,     drain_d;
    logic              pend_q,      pend_d;
    logic [ADDR_W-1:0] pend_base_q, pend_base_d;
    logic [ADDR_W:0]   pend_len_q,  pend_len_d;
    logic              overrun_q,   overrun_d;

    logic              w_req_ok;
    logic              w_engine;
    logic              w_last_read;
    logic              w_drain_last;
    logic              w_rd_valid;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_wr_valid;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_req_ok     = copy_req && (copy_len != '0);
    assign w_engine     = (state_q == ST_COPY) || (state_q == ST_DRAIN);
    assign w_last_read  = (cnt_q == (len_q - (ADDR_W+1)'(1)));
    assign w_drain_last = (drain_q == 2'(READ_LATENCY - 1));
    assign w_rd_valid   = (state_q == ST_COPY);
    // Address arithmetic is ADDR_W wide so the copy wraps modulo the depth
    assign w_rd_addr    = base_q + cnt_q[ADDR_W-1:0];

    // Next-state logic for the copy sequencer and the one-deep request queue
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;
        pend_len_d  = pend_len_q;
        overrun_d   = overrun_q;

        if (copy_req) begin
            overrun_d = 1'b0;
        end
        // A copy still running after vblank fell wins over a clearing request
        if (w_engine && !vblank) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_ARMED;
                    base_d  = pend_base_q;
                    len_d   = pend_len_q;
                    pend_d  = 1'b0;
                end else if (w_req_ok) begin
                    state_d = ST_ARMED;
                    base_d  = copy_base;
                    len_d   = copy_len;
                end
            end
            ST_ARMED: begin
                if (vblank_start) begin
                    state_d = ST_COPY;
                    cnt_d   = '0;
                end
            end
            ST_COPY: begin
                if (w_last_read) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    if (pend_q) begin
                        state_d = ST_ARMED;
                        base_d  = pend_base_q;
                        len_d   = pend_len_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests arriving while busy queue one deep; later ones are dropped
        if ((state_q != ST_IDLE) && w_req_ok && !pend_q) begin
            pend_d      = 1'b1;
            pend_base_d = copy_base;
            pend_len_d  = copy_len;
        end
    end

    // Sequencer registers; reset abandons any copy and the pending request
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            pend_q      <= 1'b0;
            pend_base_q <= '0;
            pend_len_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            pend_q      <= pend_d;
            pend_base_q <= pend_base_d;
            pend_len_q  <= pend_len_d;
            overrun_q   <= overrun_d;
        end
    end

    frame_copy_pipe #(
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_valid (w_rd_valid),
        .i_addr  (w_rd_addr),
        .o_valid (w_wr_valid),
        .o_addr  (w_wr_addr)
    );

    // Memory ownership mux: engine while copying/draining, CPU otherwise
    always_comb begin
        cpu_waitrequest = 1'b0;
        pix_address     = '0;
        pix_wren        = 1'b0;
        pix_data        = '0;
        shd_address     = '0;
        shd_wren        = 1'b0;
        shd_data        = '0;
        if (w_engine) begin
            cpu_waitrequest = cpu_chipselect;
            shd_address     = w_rd_valid ? w_rd_addr : '0;
            pix_wren        = w_wr_valid;
            pix_address     = w_wr_valid ? w_wr_addr : '0;
            pix_data        = w_wr_valid ? shd_q : '0;
        end else if (cpu_chipselect) begin
            if (cpu_sel_shadow) begin
                shd_address = cpu_address;
                shd_data    = cpu_writedata;
                shd_wren    = cpu_write;
            end else begin
                pix_address = cpu_address;
                pix_data    = cpu_writedata;
                pix_wren    = cpu_write;
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

`ifdef FRAME_COPY_IRQ_EN
    logic irq_q, irq_d;

    // Completion flag raised after the last drain cycle; set beats ack
    always_comb begin
        irq_d = irq_q;
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if ((state_q == ST_DRAIN) && w_drain_last) begin
            irq_d = 1'b1;
        end
    end

    // Completion interrupt register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign copy_done_irq = irq_q;
`endif

endmodule : frame_copy_controller
`default_nettype wire

// File: tb/tb_frame_copy_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_copy_controller
// Description : Self-checking bench for frame_copy_controller with
//               behavioural shadow/pixel RAM models and a write log that is
//               compared against copy sequences derived from base/len.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_copy_controller;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          copy_req;
    logic [AW-1:0] copy_base;
    logic [AW:0]   copy_len;
    logic          vblank_start;
    logic          vblank;
    logic [AW-1:0] cpu_address;
    logic          cpu_chipselect;
    logic          cpu_sel_shadow;
    logic          cpu_write;
    logic [DW-1:0] cpu_writedata;
    logic          cpu_waitrequest;
    logic [AW-1:0] pix_address;
    logic          pix_wren;
    logic [DW-1:0] pix_data;
    logic [AW-1:0] shd_address;
    logic          shd_wren;
    logic [DW-1:0] shd_data;
    logic [DW-1:0] shd_q = '0;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    frame_copy_controller #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .copy_req        (copy_req),
        .copy_base       (copy_base),
        .copy_len        (copy_len),
        .vblank_start    (vblank_start),
        .vblank          (vblank),
        .cpu_address     (cpu_address),
        .cpu_chipselect  (cpu_chipselect),
        .cpu_sel_shadow  (cpu_sel_shadow),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_waitrequest (cpu_waitrequest),
        .pix_address     (pix_address),
        .pix_wren        (pix_wren),
        .pix_data        (pix_data),
        .shd_address     (shd_address),
        .shd_wren        (shd_wren),
        .shd_data        (shd_data),
        .shd_q           (shd_q),
        .busy            (busy),
        .overrun         (overrun)
    );

    // Behavioural RAMs and pixel write log
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] shd_mem [DEPTH];
    logic [DW-1:0] pix_mem [DEPTH];
    logic [DW-1:0] rd_next = '0;
    wr_t           wr_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Ports are sampled mid-cycle; writes take effect, reads return old data
    always @(negedge clk) begin
        rd_next <= shd_mem[shd_address];
        if (shd_wren) shd_mem[shd_address] <= shd_data;
        if (pix_wren) begin
            pix_mem[pix_address] <= pix_data;
            wr_q.push_back('{a: pix_address, d: pix_data});
        end
    end

    // One-cycle registered read port of the shadow RAM
    always @(posedge clk) shd_q <= rd_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [AW-1:0] b, input logic [AW:0] l);
        copy_req  = 1'b1;
        copy_base = b;
        copy_len  = l;
        tick();
        copy_req  = 1'b0;
    endtask

    // Pulse vblank_start and follow the copy for len+RL cycles
    task automatic run(input int len, input bit drop_vb, input bit cpu_mid,
                       input bit pend_inj, input logic [AW-1:0] pb, input logic [AW:0] pl);
        int busy_cyc = 0;
        int wait_err = 0;
        vblank       = 1'b1;
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        for (int c = 0; c < len + RL; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (cpu_mid && c >= 10 && cpu_waitrequest !== 1'b1) wait_err++;
            if (drop_vb && c == len / 2) vblank = 1'b0;
            if (cpu_mid && c == 9) begin
                cpu_chipselect = 1'b1; cpu_sel_shadow = 1'b0; cpu_write = 1'b1;
                cpu_address = 13'h0100; cpu_writedata = 8'h55;
            end
            if (pend_inj && c == 5) begin copy_req = 1'b1; copy_base = pb; copy_len = pl; end
            if (pend_inj && c == 8) begin copy_req = 1'b1; copy_base = pb + 13'd3; copy_len = 14'd5; end
            if (pend_inj && (c == 6 || c == 9)) copy_req = 1'b0;
        end
        check("busy_cycles", busy_cyc, len + RL);
        @(negedge clk);
        check("busy_after_copy", {31'd0, busy}, {31'd0, pend_inj});
        if (cpu_mid) begin
            check("cpu_wait_hold", wait_err, 0);
            check("cpu_wait_release", {31'd0, cpu_waitrequest}, 0);
            check("cpu_pix_wren_after", {31'd0, pix_wren}, 1);
        end
        tick();
        cpu_chipselect = 1'b0;
        cpu_write      = 1'b0;
        vblank         = 1'b1;
    endtask

    // Compare logged writes with (base+i) mod depth and shadow contents
    task automatic verify(input string tag, input logic [AW-1:0] b, input int len);
        int errs = 0;
        logic [AW-1:0] a;
        check({tag, "_count"}, wr_q.size(), len);
        for (int i = 0; i < len && i < wr_q.size(); i++) begin
            a = AW'((int'(b) + i) % DEPTH);
            if (wr_q[i].a !== a || wr_q[i].d !== shd_mem[a]) errs++;
        end
        check({tag, "_seq_errs"}, errs, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int n;
        logic [AW-1:0] rb;
        logic [AW:0]   rl;

        rst_n = 1'b0; copy_req = 1'b0; copy_base = '0; copy_len = '0;
        vblank_start = 1'b0; vblank = 1'b1;
        cpu_address = '0; cpu_chipselect = 1'b0; cpu_sel_shadow = 1'b0;
        cpu_write = 1'b0; cpu_writedata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            shd_mem[i] = DW'($urandom);
            pix_mem[i] = '0;
        end
        repeat (3) tick();

        // Reset state
        check("rst_busy",     {31'd0, busy}, 0);
        check("rst_overrun",  {31'd0, overrun}, 0);
        check("rst_wait",     {31'd0, cpu_waitrequest}, 0);
        check("rst_pix_wren", {31'd0, pix_wren}, 0);
        check("rst_shd_wren", {31'd0, shd_wren}, 0);
        check("rst_pix_addr", {19'd0, pix_address}, 0);
        check("rst_shd_addr", {19'd0, shd_address}, 0);
        rst_n = 1'b1;
        tick();

        // CPU writes into shadow while idle route straight through
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            cpu_chipselect = 1'b1; cpu_sel_shadow = 1'b1; cpu_write = 1'b1;
            cpu_address = AW'($urandom); cpu_writedata = DW'($urandom);
            #1;
            if (shd_wren !== 1'b1 || shd_address !== cpu_address || shd_data !== cpu_writedata
                || pix_wren !== 1'b0 || cpu_waitrequest !== 1'b0) errs++;
            tick();
        end
        cpu_chipselect = 1'b0; cpu_write = 1'b0;
        tick();
        check("idle_shadow_mux_errs", errs, 0);
        check("idle_shadow_landed", {24'd0, shd_mem[cpu_address]}, {24'd0, cpu_writedata});

        // Zero-length request: no arming, no traffic
        wr_q.delete();
        arm(13'h0123, '0);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0) errs++;
            if (i == 3) vblank_start = 1'b1;
            tick();
            vblank_start = 1'b0;
        end
        check("len0_busy_errs", errs, 0);
        check("len0_no_writes", wr_q.size(), 0);

        // Full-frame copy
        wr_q.delete();
        arm('0, 14'd8192);
        tick();
        check("armed_busy", {31'd0, busy}, 1);
        run(8192, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        verify("full", '0, 8192);
        errs = 0;
        for (int i = 0; i < DEPTH; i++) if (pix_mem[i] !== shd_mem[i]) errs++;
        check("full_pix_eq_shd", errs, 0);
        check("full_no_overrun", {31'd0, overrun}, 0);

        // Wrap at the top of the buffer
        wr_q.delete();
        arm(13'h1FFE, 14'd4);
        run(4, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        verify("wrap", 13'h1FFE, 4);
        if (wr_q.size() == 4) check("wrap_third_addr", {19'd0, wr_q[2].a}, 0);
        else check("wrap_third_addr", wr_q.size(), 4);

        // Random copies
        for (int k = 0; k < 5; k++) begin
            wr_q.delete();
            rb = AW'($urandom_range(0, DEPTH - 1));
            rl = (AW+1)'($urandom_range(1, 300));
            arm(rb, rl);
            run(int'(rl), 1'b0, 1'b0, 1'b0, '0, '0);
            tick();
            verify("rand", rb, int'(rl));
        end

        // CPU pixel write stalled mid-copy, lands after drain
        wr_q.delete();
        arm(13'h0080, 14'd512);
        run(512, 1'b0, 1'b1, 1'b0, '0, '0);
        tick();
        if (wr_q.size() > 0) begin
            check("cpu_late_addr", {19'd0, wr_q[$].a}, 32'h100);
            check("cpu_late_data", {24'd0, wr_q[$].d}, 32'h55);
            void'(wr_q.pop_back());
        end else begin
            check("cpu_late_write_seen", 0, 1);
        end
        verify("cpu_mid", 13'h0080, 512);
        check("cpu_pix_0100", {24'd0, pix_mem[13'h0100]}, 32'h55);

        // Vblank falls during a full copy
        wr_q.delete();
        arm(13'h0555, 14'd8192);
        run(8192, 1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        verify("overrun", 13'h0555, 8192);
        check("overrun_set", {31'd0, overrun}, 1);
        arm('0, '0);
        check("overrun_cleared", {31'd0, overrun}, 0);
        check("overrun_len0_idle", {31'd0, busy}, 0);

        // Pending request runs on the next vblank, third one dropped
        wr_q.delete();
        rb = AW'($urandom_range(0, DEPTH - 1));
        arm(13'h1F00, 14'd40);
        run(40, 1'b0, 1'b0, 1'b1, rb, 14'd20);
        tick();
        verify("pend_a", 13'h1F00, 40);
        wr_q.delete();
        repeat (3) tick();
        run(20, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        verify("pend_b", rb, 20);
        wr_q.delete();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        repeat (20) tick();
        check("third_req_dropped", wr_q.size(), 0);
        check("third_req_idle", {31'd0, busy}, 0);

        // Reset in the middle of a copy with a request pending
        wr_q.delete();
        arm(13'h0400, 14'd1000);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        repeat (5) tick();
        copy_req = 1'b1; copy_base = 13'h0010; copy_len = 14'd10;
        tick();
        copy_req = 1'b0;
        repeat (50) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",     {31'd0, busy}, 0);
        check("midrst_pix_wren", {31'd0, pix_wren}, 0);
        check("midrst_wait",     {31'd0, cpu_waitrequest}, 0);
        check("midrst_pix_addr", {19'd0, pix_address}, 0);
        check("midrst_shd_addr", {19'd0, shd_address}, 0);
        n = wr_q.size();
        check("midrst_partial", {31'd0, (n > 0 && n < 1000)}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr_q.delete();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        repeat (20) tick();
        check("midrst_pending_lost", wr_q.size(), 0);
        check("midrst_idle", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_frame_copy_controller
`default_nettype wire
